// File: rtl/rf_fill_controller_pkg.sv
// Shared types and constants for the RF fill controller.
// Holds the FSM encoding, buffer IDs and the RF depth sanity check.
package rf_fill_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_READ,
        S_LAST,
        S_FINISH
    } fill_state_e;

    localparam logic BUF1 = 1'b0;
    localparam logic BUF2 = 1'b1;

    localparam int RF_ADDR_BITWIDTH_DEF = 2;
    localparam int RF_DEPTH_DEF         = 4;

    function automatic bit rf_depth_ok(input int depth, input int aw);
        return depth == (1 << aw);
    endfunction

endpackage

// File: rtl/rf_req_arbiter.sv
// Two-requester round-robin for the RF double buffers.
// Ties go to the buffer not served last; a clear makes rf1 win next.
module rf_req_arbiter
    import rf_fill_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic req1,
    input  logic req2,
    input  logic update,
    input  logic served,
    output logic grant
);

    logic last_served_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_served_q <= BUF2;
        end else if (update) begin
            last_served_q <= served;
        end
    end

    always_comb begin
        grant = BUF1;
        if (req1 && req2) begin
            grant = ~last_served_q;
        end else if (req2) begin
            grant = BUF2;
        end
    end

endmodule

// File: rtl/rf_fill_controller.sv
// Streams GBF words into the PE array register files, one
// RF_DEPTH-word burst per need_data request, alternating buffers.
module rf_fill_controller
    import rf_fill_controller_pkg::*;
#(
    parameter int ROW               = 16,
    parameter int COL               = 16,
    parameter int RF_ADDR_BITWIDTH  = RF_ADDR_BITWIDTH_DEF,
    parameter int RF_DEPTH          = RF_DEPTH_DEF,
    parameter int GBF_ADDR_BITWIDTH = 8,
    parameter int GBF_DATA_BITWIDTH = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [GBF_ADDR_BITWIDTH-1:0] cfg_gbf_base,
    input  logic [15:0]                  cfg_fills,
    input  logic [ROW*COL-1:0]           cfg_en_mask,
    input  logic                         rf1_need_data,
    input  logic                         rf2_need_data,
    input  logic                         turn_off,
    output logic                         gbf_rd_en,
    output logic [GBF_ADDR_BITWIDTH-1:0] gbf_rd_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0] gbf_rd_data,
    output logic [ROW*COL-1:0]           rf_en,
    output logic [RF_ADDR_BITWIDTH-1:0]  rf_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0] rf_data,
    output logic                         data_avail,
    output logic                         buf1_send_finish,
    output logic                         buf2_send_finish,
    output logic                         busy,
    output logic                         done
);

    localparam int PES = ROW * COL;
    localparam logic [RF_ADDR_BITWIDTH-1:0] LAST_WORD =
        RF_ADDR_BITWIDTH'(RF_DEPTH - 1);

    if (!rf_depth_ok(RF_DEPTH, RF_ADDR_BITWIDTH)) begin : g_bad_depth
        $error("RF_DEPTH must equal 2**RF_ADDR_BITWIDTH");
    end

    fill_state_e state_q, state_d;

    logic                         target_q;
    logic [15:0]                  fills_left_q;
    logic [GBF_ADDR_BITWIDTH-1:0] gbf_ptr_q;
    logic [RF_ADDR_BITWIDTH-1:0]  word_q;
    logic [PES-1:0]               en_mask_q;
    logic                         wr_valid_q;
    logic [RF_ADDR_BITWIDTH-1:0]  wr_addr_q;
    logic                         data_avail_q;
    logic                         done_q;

    logic rd_en;
    logic run_start;
    logic zero_start;
    logic take_req;
    logic finish_entry;
    logic end_run;
    logic need_sel;
    logic grant;

    assign need_sel = (target_q == BUF2) ? rf2_need_data : rf1_need_data;

    rf_req_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .clear  (abort || run_start),
        .req1   (rf1_need_data),
        .req2   (rf2_need_data),
        .update (finish_entry),
        .served (target_q),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        run_start    = 1'b0;
        zero_start   = 1'b0;
        take_req     = 1'b0;
        finish_entry = 1'b0;
        end_run      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (cfg_fills == '0)) begin
                    zero_start = 1'b1;
                end else if (start) begin
                    run_start = 1'b1;
                    state_d   = S_WAIT_REQ;
                end
            end
            S_WAIT_REQ: begin
                if (fills_left_q == '0) begin
                    end_run = 1'b1;
                    state_d = S_IDLE;
                end else if (rf1_need_data || rf2_need_data) begin
                    take_req = 1'b1;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
                if (word_q == LAST_WORD) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                finish_entry = 1'b1;
                state_d      = S_FINISH;
            end
            S_FINISH: begin
                if (turn_off || !need_sel) begin
                    state_d = S_WAIT_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write side trails the read strobe by one cycle to meet GBF latency.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            target_q     <= BUF1;
            fills_left_q <= '0;
            gbf_ptr_q    <= '0;
            word_q       <= '0;
            en_mask_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            data_avail_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            wr_valid_q <= rd_en;
            wr_addr_q  <= rd_en ? word_q : '0;
            done_q     <= zero_start || end_run;
            if (run_start) begin
                en_mask_q    <= cfg_en_mask;
                gbf_ptr_q    <= cfg_gbf_base;
                fills_left_q <= cfg_fills;
                word_q       <= '0;
                data_avail_q <= 1'b0;
            end
            if (take_req) begin
                target_q <= grant;
                word_q   <= '0;
            end
            if (rd_en) begin
                gbf_ptr_q <= gbf_ptr_q + 1'b1;
                word_q    <= word_q + 1'b1;
            end
            if (finish_entry) begin
                fills_left_q <= fills_left_q - 16'd1;
                data_avail_q <= 1'b1;
            end
            if (end_run) begin
                data_avail_q <= 1'b0;
            end
        end
    end

    assign gbf_rd_en        = rd_en;
    assign gbf_rd_addr      = rd_en ? gbf_ptr_q : '0;
    assign rf_en            = wr_valid_q ? en_mask_q : '0;
    assign rf_w_addr        = wr_addr_q;
    assign rf_data          = wr_valid_q ? gbf_rd_data : '0;
    assign data_avail       = data_avail_q;
    assign buf1_send_finish = (state_q == S_FINISH) && (target_q == BUF1);
    assign buf2_send_finish = (state_q == S_FINISH) && (target_q == BUF2);
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

endmodule

// File: tb/tb_rf_fill_controller.sv
// Scoreboard bench for rf_fill_controller with a GBF memory model
// and a reference model of read order, write stream and buffer service.
module tb_rf_fill_controller;

    localparam int PES = 256;
    localparam int DW  = 512;

    logic           clk = 1'b0;
    logic           reset, start, abort, turn_off;
    logic           rf1_need_data, rf2_need_data;
    logic [7:0]     cfg_gbf_base;
    logic [15:0]    cfg_fills;
    logic [PES-1:0] cfg_en_mask;
    logic           gbf_rd_en;
    logic [7:0]     gbf_rd_addr;
    logic [DW-1:0]  gbf_rd_data;
    logic [PES-1:0] rf_en;
    logic [1:0]     rf_w_addr;
    logic [DW-1:0]  rf_data;
    logic           data_avail, buf1_send_finish, buf2_send_finish;
    logic           busy, done;

    logic [DW-1:0]  gbf_mem [256];

    typedef struct {
        logic [PES-1:0] mask;
        logic [1:0]     widx;
        logic [DW-1:0]  data;
    } wr_t;

    logic [7:0] exp_rd[$];
    wr_t        exp_wr[$];
    logic       exp_fin[$];

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int wr_count = 0;
    int last_fin = -1;
    bit mon_en   = 1'b0;
    bit fin_prev = 1'b0;
    wr_t mw;

    rf_fill_controller dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .cfg_gbf_base     (cfg_gbf_base),
        .cfg_fills        (cfg_fills),
        .cfg_en_mask      (cfg_en_mask),
        .rf1_need_data    (rf1_need_data),
        .rf2_need_data    (rf2_need_data),
        .turn_off         (turn_off),
        .gbf_rd_en        (gbf_rd_en),
        .gbf_rd_addr      (gbf_rd_addr),
        .gbf_rd_data      (gbf_rd_data),
        .rf_en            (rf_en),
        .rf_w_addr        (rf_w_addr),
        .rf_data          (rf_data),
        .data_avail       (data_avail),
        .buf1_send_finish (buf1_send_finish),
        .buf2_send_finish (buf2_send_finish),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) gbf_rd_data <= gbf_mem[gbf_rd_addr];

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents traffic.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gbf_rd_en) begin
                check("rd_expected", DW'(exp_rd.size() != 0), DW'(1));
                if (exp_rd.size() != 0)
                    check("rd_addr", DW'(gbf_rd_addr), DW'(exp_rd.pop_front()));
            end
            if (rf_en != '0) begin
                wr_count <= wr_count + 1;
                check("wr_expected", DW'(exp_wr.size() != 0), DW'(1));
                if (exp_wr.size() != 0) begin
                    mw = exp_wr.pop_front();
                    check("wr_mask", DW'(rf_en), DW'(mw.mask));
                    check("wr_addr", DW'(rf_w_addr), DW'(mw.widx));
                    check("wr_data", rf_data, mw.data);
                end
            end
            if (!busy) begin
                last_fin <= -1;
            end else if ((buf1_send_finish || buf2_send_finish) && !fin_prev) begin
                check("fin_expected", DW'(exp_fin.size() != 0), DW'(1));
                if (exp_fin.size() != 0)
                    check("fin_buf", DW'(buf2_send_finish), DW'(exp_fin.pop_front()));
                check("fin_avail", DW'(data_avail), DW'(1));
                if (last_fin >= 0)
                    check("fin_period", DW'(cyc_cnt - last_fin), DW'(7));
                last_fin <= cyc_cnt;
            end
        end
        fin_prev <= buf1_send_finish || buf2_send_finish;
    end

    // Reference model: linear GBF walk, fixed word order, round-robin service.
    task automatic push_expect(input logic [7:0] base, input int fills,
                               input logic [PES-1:0] mask, input int mode);
        logic [7:0] a;
        logic       last;
        logic       s;
        wr_t        w;
        last = 1'b1;
        for (int k = 0; k < fills * 4; k++) begin
            a = base + 8'(k);
            exp_rd.push_back(a);
            w.mask = mask;
            w.widx = 2'(k % 4);
            w.data = gbf_mem[a];
            exp_wr.push_back(w);
        end
        for (int f = 0; f < fills; f++) begin
            s = (mode == 0) ? ~last : (mode == 2);
            exp_fin.push_back(s);
            last = s;
        end
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_fin.delete();
    endtask

    task automatic kick(input logic [7:0] base, input int fills,
                        input logic [PES-1:0] mask);
        cfg_gbf_base = base;
        cfg_fills    = 16'(fills);
        cfg_en_mask  = mask;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit drive_off);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (drive_off) turn_off = buf1_send_finish || buf2_send_finish;
            if (done) begin
                seen = 1'b1;
                check("done_busy", DW'(busy), DW'(0));
                check("done_avail", DW'(data_avail), DW'(0));
            end
        end
        check("done_seen", DW'(seen), DW'(1));
        turn_off = 1'b0;
    endtask

    task automatic end_checks(input int wr0, input int fills);
        rf1_need_data = 1'b0;
        rf2_need_data = 1'b0;
        @(posedge clk); #1;
        check("done_width", DW'(done), DW'(0));
        check("rd_left", DW'(exp_rd.size()), DW'(0));
        check("wr_left", DW'(exp_wr.size()), DW'(0));
        check("fin_left", DW'(exp_fin.size()), DW'(0));
        check("wr_count", DW'(wr_count - wr0), DW'(fills * 4));
        flush();
    endtask

    task automatic run_fills(input logic [7:0] base, input int fills,
                             input logic [PES-1:0] mask, input int mode);
        int wr0;
        push_expect(base, fills, mask, mode);
        wr0 = wr_count;
        rf1_need_data = (mode != 2);
        rf2_need_data = (mode != 1);
        kick(base, fills, mask);
        check("busy_after_start", DW'(busy), DW'(1));
        wait_done(fills * 8 + 10, 1'b1);
        end_checks(wr0, fills);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_rd_en"}, DW'(gbf_rd_en), DW'(0));
        check({nm, "_rd_addr"}, DW'(gbf_rd_addr), DW'(0));
        check({nm, "_rf_en"}, DW'(rf_en), DW'(0));
        check({nm, "_w_addr"}, DW'(rf_w_addr), DW'(0));
        check({nm, "_rf_data"}, rf_data, DW'(0));
        check({nm, "_avail"}, DW'(data_avail), DW'(0));
        check({nm, "_fin1"}, DW'(buf1_send_finish), DW'(0));
        check({nm, "_fin2"}, DW'(buf2_send_finish), DW'(0));
        check({nm, "_busy"}, DW'(busy), DW'(0));
        check({nm, "_done"}, DW'(done), DW'(0));
    endtask

    task automatic reach_read(input string nm);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (gbf_rd_en) found = 1'b1;
        end
        check(nm, DW'(found), DW'(1));
    endtask

    initial begin
        logic [PES-1:0] m;
        int             wr0;
        bit             bad;

        for (int i = 0; i < 256; i++)
            for (int j = 0; j < DW / 32; j++)
                gbf_mem[i][j*32 +: 32] = $urandom;

        reset = 1'b1; start = 1'b0; abort = 1'b0; turn_off = 1'b0;
        rf1_need_data = 1'b0; rf2_need_data = 1'b0;
        cfg_gbf_base = '0; cfg_fills = '0; cfg_en_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single fill with cycle-exact timing from the request.
        push_expect(8'h10, 1, '1, 1);
        wr0 = wr_count;
        kick(8'h10, 1, '1);
        rf1_need_data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t_rd_en", DW'(gbf_rd_en), DW'(i >= 1 && i <= 4));
            check("t_rf_en", DW'(rf_en != '0), DW'(i >= 2 && i <= 5));
            check("t_fin1", DW'(buf1_send_finish), DW'(i >= 6));
        end
        @(posedge clk); #1;
        rf1_need_data = 1'b0;
        wait_done(6, 1'b0);
        end_checks(wr0, 1);

        run_fills(8'h20, 4, '1, 0);
        run_fills(8'hFE, 1, '1, 1);
        m = '0;
        m[0] = 1'b1;
        m[255] = 1'b1;
        run_fills(8'h40, 1, m, 1);

        // Zero fills: done one cycle after start, no traffic.
        kick(8'h00, 0, '1);
        check("zero_done", DW'(done), DW'(1));
        check("zero_busy", DW'(busy), DW'(0));
        check("zero_rd", DW'(gbf_rd_en), DW'(0));
        @(posedge clk); #1;
        check("zero_done_drop", DW'(done), DW'(0));

        // Abort on the second read cycle.
        mon_en = 1'b0;
        rf1_need_data = 1'b1;
        rf2_need_data = 1'b1;
        kick(8'($urandom), 3, '1);
        reach_read("abort_reach_read");
        @(posedge clk); #1;
        abort = 1'b1;
        check("abort_2nd_read", DW'(gbf_rd_en), DW'(1));
        @(posedge clk); #1;
        abort = 1'b0;
        check_zero("abort");
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || buf1_send_finish || buf2_send_finish || busy) bad = 1'b1;
        end
        check("abort_quiet", DW'(bad), DW'(0));
        rf1_need_data = 1'b0;
        rf2_need_data = 1'b0;
        flush();
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_fills(8'h80, 2, '1, 0);

        // Reset in the middle of a burst.
        mon_en = 1'b0;
        rf1_need_data = 1'b1;
        kick(8'h33, 2, '1);
        reach_read("reset_reach_read");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_mid");
        reset = 1'b0;
        rf1_need_data = 1'b0;
        flush();
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_fills(8'h50, 2, '1, 0);

        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < PES / 32; j++) m[j*32 +: 32] = $urandom;
            run_fills(8'($urandom), int'($urandom_range(1, 5)), m,
                      int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_fill_controller.md
# rf_fill_controller

- Sequences one operand stream (activation or weight) from the global buffer (GBF) SRAM into the PE array's double-buffered register files.
- Answers the per-buffer `need_data` requests raised by the PE array controller. For each request it issues a burst of GBF reads and drives the write-enable, address and data bus into the selected PEs, then signals `bufN_send_finish`.
- Two instances sit between the GBF and the PE array: one for activations, one for weights.

## Interface
- `ROW`, 16, PE array rows
- `COL`, 16, PE array columns
- `RF_ADDR_BITWIDTH`, 2, RF write-address width
- `RF_DEPTH`, 4, words per RF fill; must equal 2^RF_ADDR_BITWIDTH
- `GBF_ADDR_BITWIDTH`, 8, GBF read-address width
- `GBF_DATA_BITWIDTH`, 512, GBF word / RF data bus width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; latches all `cfg_*` inputs
- `abort`  in  1  synchronous abort to IDLE
- `cfg_gbf_base`  in  GBF_ADDR_BITWIDTH  first GBF word address
- `cfg_fills`  in  16  total RF fills for this layer
- `cfg_en_mask`  in  ROW*COL  PEs written on each fill
- `rf1_need_data`, `rf2_need_data`  in  1 each  level requests from the PE array controller
- `turn_off`  in  1  clears a held send_finish
- `gbf_rd_en`  out  1  GBF read strobe
- `gbf_rd_addr`  out  GBF_ADDR_BITWIDTH  GBF read address
- `gbf_rd_data`  in  GBF_DATA_BITWIDTH  valid exactly 1 cycle after `gbf_rd_en`
- `rf_en`  out  ROW*COL  per-PE write enable
- `rf_w_addr`  out  RF_ADDR_BITWIDTH  RF write address
- `rf_data`  out  GBF_DATA_BITWIDTH  RF write data, equal to `gbf_rd_data`
- `data_avail`  out  1  at least one fill completed in this run
- `buf1_send_finish`, `buf2_send_finish`  out  1 each  fill of buffer N complete
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse after the last fill

## Operation
- States: IDLE, WAIT_REQ, READ, LAST, FINISH.
- IDLE:
  - `start` latches `cfg_*`, sets `gbf_ptr` = base and `fills_left` = cfg_fills, then goes to WAIT_REQ.
  - If `cfg_fills` == 0, `done` pulses the next cycle and the FSM stays in IDLE.
- WAIT_REQ:
  - If `fills_left` == 0: pulse `done`, go to IDLE.
  - Else, when a need_data is high, latch the target buffer and go to READ.
  - If both requests are high, serve the buffer not served last; the first service of a run goes to rf1.
- READ:
  - Issue `RF_DEPTH` consecutive reads with `gbf_rd_addr` = `gbf_ptr`, incrementing each cycle. The address wraps modulo 2^GBF_ADDR_BITWIDTH.
  - The word counter runs 0..RF_DEPTH-1. After the last issue, go to LAST.
- LAST: the final write completes; go to FINISH.
- FINISH:
  - Assert the target's `bufN_send_finish`, decrement `fills_left`, set `data_avail`, and toggle `last_served`.
  - Hold `bufN_send_finish` until `turn_off` is high or that buffer's need_data is low, then return to WAIT_REQ.
- Write path: `rf_en` = `cfg_en_mask` and `rf_w_addr` = the word index, both registered one cycle after the matching `gbf_rd_en`. `rf_en` is all-zero otherwise.
- `abort`, or `start` while `busy`:
  - `abort` takes priority: next cycle is IDLE with all outputs at their reset values. Any in-flight write is suppressed (`rf_en` = 0). `done` does not pulse.
  - `start` while `busy` is ignored.
- `reset` (including mid-burst): all outputs are 0, state is IDLE, `last_served` = rf2 (so rf1 is served first).

## Timing
- Request sampled high in WAIT_REQ at cycle t:
  - `gbf_rd_en` high during t+1 .. t+RF_DEPTH.
  - `rf_en` high during t+2 .. t+RF_DEPTH+1.
  - `bufN_send_finish` rises at t+RF_DEPTH+2.
- Minimum turnaround from FINISH back to WAIT_REQ is 1 cycle. With DEPTH=4, back-to-back fills take 7 cycles each.
- `data_avail`: rises with the first send_finish; falls on `done`, `abort` or `reset`.
- `busy`: high from the cycle after `start` until the cycle `done` pulses.

## Structure
- A shared package holds: the state encoding, the buffer-ID constants (BUF1 = 0, BUF2 = 1), and the `RF_DEPTH`/`RF_ADDR_BITWIDTH` consistency check.
- One natural sub-module, `rf_req_arbiter`: two-requester round-robin with a `last_served` register and a `grant` output. It is reused by the weight instance.
- Everything else is a single flat module: FSM, `gbf_ptr`/word counter, one-stage write-alignment register.

## Test plan
- **Single fill:** base = 0x10, fills = 1, mask = all-ones; raise rf1_need at t=5.
  - Reads at 0x10..0x13 in t=6..9.
  - `rf_w_addr` 0..3 in t=7..10.
  - `buf1_send_finish` at t=11; `done` after the request drops.
- **Alternation:** both need_data held high, fills = 4 → served order rf1, rf2, rf1, rf2. GBF addresses are contiguous: base..base+15.
- **Wrap:** base = 0xFE, fills = 1 → reads at 0xFE, 0xFF, 0x00, 0x01.
- **Mask:** mask with only PE 0 and PE 255 set → `rf_en` = mask for exactly 4 cycles; `rf_data` matches the GBF model word-for-word.
- **Abort:** `abort` asserted on the 2nd read cycle → next cycle `rf_en` = 0, `busy` = 0, no send_finish, no `done`. A new `start` afterwards runs cleanly.
- **Zero / reset:** `cfg_fills` = 0 → `done` one cycle after `start`, no reads. `reset` mid-burst → all outputs 0 on the next cycle.
